// File: rtl/mem_arbiter.sv
// Two-port (instruction fetch / data) arbiter in front of a single-request memory controller.
// Define MEM_ARB_RR_EN for round-robin on simultaneous requests; otherwise data has fixed priority.
`timescale 1ns/1ps
module mem_arbiter #(
  parameter int ADDR_W = 17,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_done,
  input  logic              d_req,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  input  logic              d_we,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_done,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_write_value,
  output logic              mem_write_enable,
  output logic              mem_request,
  input  logic [DATA_W-1:0] mem_read_value,
  input  logic              mem_request_complete,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, RELEASE = 2'd2} state_t;

  state_t            state, state_nxt;
  logic              owner_d, owner_d_nxt;
  logic [ADDR_W-1:0] mem_address_nxt;
  logic [DATA_W-1:0] mem_write_value_nxt;
  logic              mem_write_enable_nxt;
  logic              mem_request_nxt;
  logic [DATA_W-1:0] if_rdata_nxt, d_rdata_nxt;
  logic              if_done_nxt, d_done_nxt, busy_nxt;
  logic              req_ok_if, req_ok_d, pick_d;

  // A port whose done is still high is not eligible in that cycle.
  assign req_ok_if = if_req && !if_done;
  assign req_ok_d  = d_req && !d_done;

`ifdef MEM_ARB_RR_EN
  logic last_owner_d, last_owner_d_nxt;  // 0 = fetch was granted last
  assign pick_d = req_ok_d && (!req_ok_if || !last_owner_d);
`else
  assign pick_d = req_ok_d;
`endif

  always_ff @(posedge clk) begin
    if (ena) begin
      if (!rst_n) begin
        state            <= IDLE;
        owner_d          <= 1'b0;
        mem_address      <= '0;
        mem_write_value  <= '0;
        mem_write_enable <= 1'b0;
        mem_request      <= 1'b0;
        if_rdata         <= '0;
        d_rdata          <= '0;
        if_done          <= 1'b0;
        d_done           <= 1'b0;
        busy             <= 1'b0;
`ifdef MEM_ARB_RR_EN
        last_owner_d     <= 1'b0;
`endif
      end else begin
        state            <= state_nxt;
        owner_d          <= owner_d_nxt;
        mem_address      <= mem_address_nxt;
        mem_write_value  <= mem_write_value_nxt;
        mem_write_enable <= mem_write_enable_nxt;
        mem_request      <= mem_request_nxt;
        if_rdata         <= if_rdata_nxt;
        d_rdata          <= d_rdata_nxt;
        if_done          <= if_done_nxt;
        d_done           <= d_done_nxt;
        busy             <= busy_nxt;
`ifdef MEM_ARB_RR_EN
        last_owner_d     <= last_owner_d_nxt;
`endif
      end
    end
  end

  always_comb begin
    state_nxt            = state;
    owner_d_nxt          = owner_d;
    mem_address_nxt      = mem_address;
    mem_write_value_nxt  = mem_write_value;
    mem_write_enable_nxt = mem_write_enable;
    mem_request_nxt      = mem_request;
    if_rdata_nxt         = if_rdata;
    d_rdata_nxt          = d_rdata;
    if_done_nxt          = 1'b0;
    d_done_nxt           = 1'b0;
`ifdef MEM_ARB_RR_EN
    last_owner_d_nxt     = last_owner_d;
`endif
    case (state)
      IDLE: begin
        if (req_ok_if || req_ok_d) begin
          owner_d_nxt     = pick_d;
          mem_request_nxt = 1'b1;
          state_nxt       = BUSY;
`ifdef MEM_ARB_RR_EN
          last_owner_d_nxt = pick_d;
`endif
          if (pick_d) begin
            mem_address_nxt      = d_addr;
            mem_write_value_nxt  = d_wdata;
            mem_write_enable_nxt = d_we;
          end else begin
            mem_address_nxt      = if_addr;
            mem_write_enable_nxt = 1'b0;
          end
        end
      end
      BUSY: begin
        if (mem_request_complete) begin
          mem_request_nxt = 1'b0;
          state_nxt       = RELEASE;
          if (owner_d) begin
            d_done_nxt = 1'b1;
            if (!mem_write_enable) d_rdata_nxt = mem_read_value;
          end else begin
            if_done_nxt  = 1'b1;
            if_rdata_nxt = mem_read_value;
          end
        end
      end
      // Keep mem_request low until the controller has dropped its completion.
      RELEASE: begin
        if (!mem_request_complete) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    busy_nxt = (state_nxt != IDLE);
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed vector table, hand-written corner sequences,
// and randomized two-port traffic checked against a transaction-level arbitration model.
`timescale 1ns/1ps
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ena = 1'b1;
  logic        if_req = 1'b0;
  logic [16:0] if_addr = '0;
  logic [15:0] if_rdata;
  logic        if_done;
  logic        d_req = 1'b0;
  logic [16:0] d_addr = '0;
  logic [15:0] d_wdata = '0;
  logic        d_we = 1'b0;
  logic [15:0] d_rdata;
  logic        d_done;
  logic [16:0] mem_address;
  logic [15:0] mem_write_value;
  logic        mem_write_enable;
  logic        mem_request;
  logic [15:0] mem_read_value = '0;
  logic        mem_request_complete = 1'b0;
  logic        busy;

  mem_arbiter #(.ADDR_W(17), .DATA_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_done(if_done),
    .d_req(d_req), .d_addr(d_addr), .d_wdata(d_wdata), .d_we(d_we),
    .d_rdata(d_rdata), .d_done(d_done),
    .mem_address(mem_address), .mem_write_value(mem_write_value),
    .mem_write_enable(mem_write_enable), .mem_request(mem_request),
    .mem_read_value(mem_read_value), .mem_request_complete(mem_request_complete),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int nchk = 0;
  int nerr = 0;

  function automatic void chk(input string nm, input logic [79:0] act, input logic [79:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endfunction

  function automatic logic [15:0] rdv(input logic [16:0] a);
    logic [16:0] t;
    t = a * 17'd40503;
    return t[15:0] ^ 16'h3C5A;
  endfunction

  // Memory controller model: completion after cur_lat cycles, held while mem_request is high.
  logic        use_fixed = 1'b1;
  logic [15:0] fixed_val = '0;
  int          fix_lat = 2;
  logic        rand_lat = 1'b0;
  int          cur_lat = 2;
  int          cnt = 0;
  always @(posedge clk) begin
    if (mem_request === 1'b1) begin
      if (cnt >= cur_lat) begin
        mem_request_complete <= 1'b1;
        mem_read_value       <= use_fixed ? fixed_val : rdv(mem_address);
      end else cnt <= cnt + 1;
    end else begin
      mem_request_complete <= 1'b0;
      cnt                  <= 0;
      cur_lat              <= rand_lat ? int'($urandom_range(0, 5)) : fix_lat;
    end
  end

  // Transaction-level reference: who should win each grant, and that each grant yields one done.
  logic        p_ena = 1'b0, p_rst_n = 1'b1, p_if_req = 1'b0, p_d_req = 1'b0;
  logic        p_if_done = 1'b0, p_d_done = 1'b0, p_d_we = 1'b0, p_mreq = 1'b0, p_cmpl = 1'b0;
  logic [16:0] p_if_addr = '0, p_d_addr = '0;
  logic [15:0] p_d_wdata = '0;
  logic        m_last_d = 1'b0, m_pending = 1'b0, m_owner_d = 1'b0, exp_d;
  bit          grant_q[$];

  always @(negedge clk) begin
    if (p_ena && !p_rst_n) begin
      m_pending = 1'b0;
      m_last_d  = 1'b0;
    end else if (mem_request === 1'b1 && p_mreq === 1'b0) begin
      if ((p_d_req && !p_d_done) && (p_if_req && !p_if_done)) begin
`ifdef MEM_ARB_RR_EN
        exp_d = !m_last_d;
`else
        exp_d = 1'b1;
`endif
      end else exp_d = p_d_req && !p_d_done;
      chk("grant_after_release", {79'd0, p_cmpl}, 80'd0);
      chk("grant_addr", {63'd0, mem_address}, {63'd0, exp_d ? p_d_addr : p_if_addr});
      chk("grant_we", {79'd0, mem_write_enable}, {79'd0, exp_d & p_d_we});
      chk("grant_busy", {79'd0, busy}, 80'd1);
      if (exp_d && p_d_we) chk("grant_wdata", {64'd0, mem_write_value}, {64'd0, p_d_wdata});
      grant_q.push_back(mem_address == p_d_addr);
      m_last_d  = exp_d;
      m_owner_d = exp_d;
      m_pending = 1'b1;
    end
    if (if_done === 1'b1 || d_done === 1'b1) begin
      chk("done_owner", {77'd0, m_pending, if_done, d_done}, {77'd0, 1'b1, !m_owner_d, m_owner_d});
      chk("done_mreq_low", {79'd0, mem_request}, 80'd0);
      m_pending = 1'b0;
    end
    p_ena = ena; p_rst_n = rst_n; p_if_req = if_req; p_d_req = d_req;
    p_if_done = if_done; p_d_done = d_done; p_d_we = d_we;
    p_mreq = mem_request; p_cmpl = mem_request_complete;
    p_if_addr = if_addr; p_d_addr = d_addr; p_d_wdata = d_wdata;
  end

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0; if_req = 1'b0; d_req = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic fetch_txn(input logic [16:0] a, input logic [15:0] exp_rd);
    bit got = 0;
    @(posedge clk); #1;
    if_addr = a; if_req = 1'b1;
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      if (if_done === 1'b1) begin got = 1; break; end
    end
    chk("if_done_seen", {79'd0, got}, 80'd1);
    if (got) chk("if_rdata", {64'd0, if_rdata}, {64'd0, exp_rd});
    @(posedge clk); #1;
    if_req = 1'b0;
  endtask

  task automatic data_txn(input logic we, input logic [16:0] a, input logic [15:0] wd,
                          input logic [15:0] exp_rd);
    bit got = 0;
    @(posedge clk); #1;
    d_addr = a; d_we = we; d_wdata = wd; d_req = 1'b1;
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      if (d_done === 1'b1) begin got = 1; break; end
    end
    chk("d_done_seen", {79'd0, got}, 80'd1);
    if (got) chk("d_rdata", {64'd0, d_rdata}, {64'd0, exp_rd});
    @(posedge clk); #1;
    d_req = 1'b0;
  endtask

  typedef struct {
    bit          is_d;
    bit          we;
    logic [16:0] addr;
    logic [15:0] wdata;
    logic [15:0] rval;
    int          lat;
    logic [15:0] exp_if_rd;
    logic [15:0] exp_d_rd;
  } vec_t;

  vec_t        tbl[6];
  logic [69:0] snap;
  logic [15:0] m_d_rd;
  bit          got;

  initial begin
    tbl[0] = '{0, 0, 17'h00100, 16'h0000, 16'hA5C3, 48, 16'hA5C3, 16'h0000};
    tbl[1] = '{1, 1, 17'h1FFFE, 16'h1234, 16'hDEAD,  3, 16'hA5C3, 16'h0000};
    tbl[2] = '{1, 0, 17'h0ABCD, 16'h0000, 16'h5A5A,  0, 16'hA5C3, 16'h5A5A};
    tbl[3] = '{1, 1, 17'h00001, 16'hFFFF, 16'h9999,  1, 16'hA5C3, 16'h5A5A};
    tbl[4] = '{0, 0, 17'h1FFFF, 16'h0000, 16'h0001,  2, 16'h0001, 16'h5A5A};
    tbl[5] = '{0, 0, 17'h00000, 16'h0000, 16'hFFFF,  0, 16'hFFFF, 16'h5A5A};

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("reset_outputs",
        {10'd0, mem_address, mem_write_value, mem_write_enable, mem_request,
         if_rdata, if_done, d_rdata, d_done, busy}, 80'd0);

    // Directed vector table.
    for (int i = 0; i < 6; i++) begin
      fixed_val = tbl[i].rval;
      fix_lat   = tbl[i].lat;
      if (tbl[i].is_d) data_txn(tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].exp_d_rd);
      else fetch_txn(tbl[i].addr, tbl[i].exp_if_rd);
      chk("vec_mem_address", {63'd0, mem_address}, {63'd0, tbl[i].addr});
      chk("vec_mem_we", {79'd0, mem_write_enable}, {79'd0, tbl[i].we});
      if (tbl[i].we) chk("vec_mem_wdata", {64'd0, mem_write_value}, {64'd0, tbl[i].wdata});
      chk("vec_if_rdata", {64'd0, if_rdata}, {64'd0, tbl[i].exp_if_rd});
      chk("vec_d_rdata", {64'd0, d_rdata}, {64'd0, tbl[i].exp_d_rd});
    end

    // Three simultaneous request pairs after reset.
    do_reset();
    fix_lat = 4; fixed_val = 16'h1111;
    grant_q.delete();
    for (int k = 0; k < 3; k++) begin
      fork
        fetch_txn(17'h00F00, 16'h1111);
        data_txn(1'b0, 17'h0D000, 16'h0000, 16'h1111);
      join
    end
    chk("pair_grant_count", 80'(grant_q.size()), 80'd6);
    for (int k = 0; k < 6 && k < grant_q.size(); k++)
      chk("pair_grant_order", {79'd0, grant_q[k]}, {79'd0, (k % 2) == 0});

    // Reset while a long read is in flight.
    fix_lat = 48; fixed_val = 16'hBEEF;
    @(posedge clk); #1;
    if_addr = 17'h00300; if_req = 1'b1;
    repeat (10) @(posedge clk);
    #1 rst_n = 1'b0; if_req = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_busy_state", {77'd0, mem_request, busy, if_done}, 80'd0);
    chk("rst_if_rdata", {64'd0, if_rdata}, 80'd0);
    repeat (5) begin
      @(negedge clk);
      chk("rst_no_done", {78'd0, if_done, d_done}, 80'd0);
    end
    fix_lat = 3;
    fetch_txn(17'h00200, 16'hBEEF);

    // Enable low for 5 cycles mid-transaction; completion arrives during the stall.
    fix_lat = 6; fixed_val = 16'h7E57;
    @(posedge clk); #1;
    d_addr = 17'h05555; d_we = 1'b0; d_req = 1'b1;
    repeat (3) @(posedge clk);
    #1 ena = 1'b0;
    snap = {mem_address, mem_write_value, mem_write_enable, mem_request,
            if_rdata, if_done, d_rdata, d_done, busy};
    chk("stall_busy", {79'd0, busy}, 80'd1);
    repeat (5) begin
      @(posedge clk); #1;
      chk("stall_frozen", {10'd0, mem_address, mem_write_value, mem_write_enable, mem_request,
                           if_rdata, if_done, d_rdata, d_done, busy}, {10'd0, snap});
    end
    ena = 1'b1;
    got = 0;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (d_done === 1'b1) begin got = 1; break; end
    end
    chk("stall_done_seen", {79'd0, got}, 80'd1);
    chk("stall_d_rdata", {64'd0, d_rdata}, {64'd0, 16'h7E57});
    @(posedge clk); #1 d_req = 1'b0;

    // Randomized traffic on both ports.
    do_reset();
    use_fixed = 1'b0; rand_lat = 1'b1; m_d_rd = 16'h0000;
    fork
      begin : rnd_fetch
        logic [16:0] a;
        for (int i = 0; i < 30; i++) begin
          repeat ($urandom_range(0, 3)) @(posedge clk);
          a = 17'($urandom);
          fetch_txn(a, rdv(a));
        end
      end
      begin : rnd_data
        logic [16:0] a;
        logic [15:0] wd;
        logic        we;
        for (int i = 0; i < 30; i++) begin
          repeat ($urandom_range(0, 3)) @(posedge clk);
          a = 17'($urandom); wd = 16'($urandom); we = 1'($urandom_range(0, 1));
          if (we) data_txn(1'b1, a, wd, m_d_rd);
          else begin
            data_txn(1'b0, a, wd, rdv(a));
            m_d_rd = rdv(a);
          end
        end
      end
    join
    repeat (10) @(posedge clk);
    chk("final_idle", {79'd0, busy}, 80'd0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", nchk, nerr);
    $fatal(1);
  end

endmodule
